// File: rtl/dcache_resp_bridge.sv
// dcache_resp_bridge: executes one memory1 load/store on a single-outstanding bus and returns load data to memory2.
// Optional DCACHE_BRIDGE_STAT_EN adds load/store completion counters.
module dcache_resp_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_is_store,
   input  logic [ADDR_W-1:0] req_pa,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [STRB_W-1:0] req_wstrb,
   output logic              dcache_ready,
   output logic [DATA_W-1:0] rd_dcache_data,
   output logic              dcache_data_valid,
   input  logic              data_ack,
   input  logic              flush,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [STRB_W-1:0] bus_wstrb,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [DATA_W-1:0] bus_rdata
`ifdef DCACHE_BRIDGE_STAT_EN
  ,output logic [31:0]       stat_ld_cnt,
   output logic [31:0]       stat_st_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, REQ, RWAIT, RESP} state_t;
   state_t state;
   logic   kill;
   assign dcache_ready = (state == IDLE);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         kill              <= 1'b0;
         dcache_data_valid <= 1'b0;
         rd_dcache_data    <= '0;
         bus_req           <= 1'b0;
         bus_we            <= 1'b0;
         bus_addr          <= '0;
         bus_wdata         <= '0;
         bus_wstrb         <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid && !flush) begin
               state     <= REQ;
               bus_req   <= 1'b1;
               bus_we    <= req_is_store;
               bus_addr  <= req_pa;
               bus_wdata <= req_wdata;
               bus_wstrb <= req_wstrb;
            end
            // The request stays up across a flush; only the kill flag records it.
            REQ: begin
               if (flush) kill <= 1'b1;
               if (bus_gnt) begin
                  bus_req <= 1'b0;
                  state   <= bus_we ? IDLE : RWAIT;
                  if (bus_we) kill <= 1'b0;
               end
            end
            RWAIT: begin
               if (flush) kill <= 1'b1;
               if (bus_rvalid) begin
                  kill <= 1'b0;
                  if (kill || flush) state <= IDLE;
                  else begin
                     rd_dcache_data    <= bus_rdata;
                     dcache_data_valid <= 1'b1;
                     state             <= RESP;
                  end
               end
            end
            RESP: if (data_ack || flush) begin
               dcache_data_valid <= 1'b0;
               state             <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef DCACHE_BRIDGE_STAT_EN
   logic ld_done, st_done;
   assign ld_done = (state == RWAIT) && bus_rvalid && !kill && !flush;
   assign st_done = (state == REQ) && bus_gnt && bus_we;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ld_cnt <= '0;
         stat_st_cnt <= '0;
      end else begin
         if (ld_done) stat_ld_cnt <= stat_ld_cnt + 32'd1;
         if (st_done) stat_st_cnt <= stat_st_cnt + 32'd1;
      end
   end
`endif
endmodule
